// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO arbiter: FSM state encoding and parameter defaults.
package fifo_arb_pkg;

  localparam int DATA_W_DEF    = 4;
  localparam int N_SRC_DEF     = 4;
  localparam int BURST_LEN_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Winner selection over a request vector: round-robin from start_ptr by default,
// lowest-index priority when FIFO_ARB_STRICT_PRIO_EN is defined (start_ptr ignored).
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start_ptr,
  output logic [IW-1:0] win,
  output logic          valid
);

`ifdef FIFO_ARB_STRICT_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^start_ptr;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        win   = IW'(i);
        valid = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] idx;

  // Scan downward so the last hit is the first requester at or after start_ptr;
  // the index wraps naturally because N is a power of two.
  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = start_ptr + IW'(k);
      if (req[idx]) begin
        win   = idx;
        valid = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/fifo_arbiter.sv
// Drains N_SRC source FIFOs into one destination FIFO in bursts of up to BURST_LEN pops.
// Define FIFO_ARB_STRICT_PRIO_EN for fixed lowest-index priority instead of round-robin.
//
// state | meaning
// IDLE  | no grant held; picks a winner when the destination has room
// SERVE | popping the granted source until burst end, source empty or afull
module fifo_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int N_SRC     = N_SRC_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        empty_in,
  input  logic [N_SRC*DATA_W-1:0] data_in,
  input  logic                    afull_out,
  output logic [N_SRC-1:0]        pop,
  output logic                    push,
  output logic [DATA_W-1:0]       data_out,
  output logic [GW-1:0]           grant_id,
  output logic                    busy
);

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [CW-1:0] burst_cnt;
  logic [GW-1:0] win;
  logic          win_valid;
  logic          pop_any;
  logic          rd_vld;
  logic [GW-1:0] rd_src;

  rr_pick #(.N(N_SRC), .IW(GW)) u_pick (
    .req      (~empty_in),
    .start_ptr(rr_ptr),
    .win      (win),
    .valid    (win_valid)
  );

  assign pop_any = (state == SERVE) && !empty_in[grant_id] && !afull_out;
  assign pop     = pop_any ? (N_SRC'(1) << grant_id) : '0;
  assign busy    = (state == SERVE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      grant_id  <= '0;
      rd_vld    <= 1'b0;
      rd_src    <= '0;
      push      <= 1'b0;
      data_out  <= '0;
    end else begin
      // Source data appears the cycle after a pop; capture it then, push one cycle later.
      rd_vld <= pop_any;
      rd_src <= grant_id;
      push   <= rd_vld;
      if (rd_vld) data_out <= data_in[rd_src*DATA_W +: DATA_W];

      case (state)
        IDLE: begin
          if (!afull_out && win_valid) begin
            grant_id <= win;
            state    <= SERVE;
          end
        end
        SERVE: begin
          if (pop_any) burst_cnt <= burst_cnt + 1'b1;
          if ((pop_any && burst_cnt == CW'(BURST_LEN - 1)) || empty_in[grant_id] || afull_out) begin
            state     <= IDLE;
            burst_cnt <= '0;
`ifdef FIFO_ARB_STRICT_PRIO_EN
            rr_ptr    <= '0;
`else
            rr_ptr    <= grant_id + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter with a behavioural model of the source FIFOs.
module tb_fifo_arbiter;
  localparam int DW = 4;
  localparam int NS = 4;
  localparam int BL = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NS-1:0]    empty_in;
  logic [NS*DW-1:0] data_in;
  logic             afull_out;
  logic [NS-1:0]    pop;
  logic             push;
  logic [DW-1:0]    data_out;
  logic [1:0]       grant_id;
  logic             busy;

  fifo_arbiter #(.DATA_W(DW), .N_SRC(NS), .BURST_LEN(BL)) dut (
    .clk      (clk),
    .rst      (rst),
    .empty_in (empty_in),
    .data_in  (data_in),
    .afull_out(afull_out),
    .pop      (pop),
    .push     (push),
    .data_out (data_out),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] q [NS][$];
  logic [DW-1:0] dout [NS];
  logic [NS-1:0] pop_prev;
  logic          af_next;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] val(input int s, input int n);
    return DW'((s * 4 + (n % 4)) ^ 5);
  endfunction

  task automatic refresh();
    for (int i = 0; i < NS; i++) begin
      empty_in[i] = (q[i].size() == 0);
      data_in[i*DW +: DW] = dout[i];
    end
  endtask

  // Latch pop just before the edge, then update FIFO model and afull after the edge.
  task automatic tick();
    #1 pop_prev = pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++)
      if (pop_prev[i] === 1'b1 && q[i].size() > 0) dout[i] = q[i].pop_front();
    afull_out = af_next;
    refresh();
    @(negedge clk);
  endtask

  int gseq [5];
  int g_a, g_b, npush;

  initial begin
`ifdef FIFO_ARB_STRICT_PRIO_EN
    gseq = '{0, 0, 1, 2, 3};
    g_a  = 1;
`else
    gseq = '{0, 1, 2, 3, 0};
    g_a  = 3;
`endif
    g_b = 1;
    af_next = 1'b0;
    afull_out = 1'b0;
    for (int i = 0; i < NS; i++) dout[i] = '0;
    for (int s = 0; s < NS; s++)
      for (int n = 0; n < ((s == 0) ? 8 : 4); n++) q[s].push_back(val(s, n));
    refresh();

    // Reset with all sources non-empty
    tick();
    tick();
    chk("rst_pop", 32'(pop), 32'(0));
    chk("rst_push", 32'(push), 32'(0));
    chk("rst_data", 32'(data_out), 32'(0));
    chk("rst_grant", 32'(grant_id), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    rst = 1'b1;

    // Bursts of 4 with one IDLE cycle between, pushes trailing pops by 2 cycles
    for (int b = 0; b < 5; b++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        chk($sformatf("rr_pop b%0d c%0d", b, c), 32'(pop), 32'(1) << gseq[b]);
        chk($sformatf("rr_grant b%0d c%0d", b, c), 32'(grant_id), 32'(gseq[b]));
        if (c >= 2) begin
          chk($sformatf("rr_push b%0d c%0d", b, c), 32'(push), 32'(1));
          chk($sformatf("rr_data b%0d c%0d", b, c), 32'(data_out), 32'(val(gseq[b], c - 2)));
        end else if (b > 0 && c == 0) begin
          chk($sformatf("rr_push b%0d c%0d", b, c), 32'(push), 32'(1));
          chk($sformatf("rr_data b%0d c%0d", b, c), 32'(data_out), 32'(val(gseq[b-1], 3)));
        end else begin
          chk($sformatf("rr_push b%0d c%0d", b, c), 32'(push), 32'(0));
        end
      end
      tick();
      chk($sformatf("rr_idle_pop b%0d", b), 32'(pop), 32'(0));
      chk($sformatf("rr_idle_busy b%0d", b), 32'(busy), 32'(0));
      chk($sformatf("rr_idle_push b%0d", b), 32'(push), 32'(1));
      chk($sformatf("rr_idle_data b%0d", b), 32'(data_out), 32'(val(gseq[b], 2)));
    end
    tick();
    chk("rr_tail_push", 32'(push), 32'(1));
    chk("rr_tail_data", 32'(data_out), 32'(val(gseq[4], 3)));
    tick();
    chk("rr_hold_push", 32'(push), 32'(0));
    chk("rr_hold_data", 32'(data_out), 32'(val(gseq[4], 3)));
    chk("rr_hold_busy", 32'(busy), 32'(0));

    // Single source: source 2 holds A, B, C
    q[2].push_back(4'hA);
    q[2].push_back(4'hB);
    q[2].push_back(4'hC);
    refresh();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("ss_pop c%0d", c), 32'(pop), 32'h4);
      chk($sformatf("ss_grant c%0d", c), 32'(grant_id), 32'(2));
    end
    chk("ss_push_a", 32'(push), 32'(1));
    chk("ss_data_a", 32'(data_out), 32'hA);
    tick();
    chk("ss_pop_end", 32'(pop), 32'(0));
    chk("ss_data_b", 32'(data_out), 32'hB);
    tick();
    chk("ss_busy_end", 32'(busy), 32'(0));
    chk("ss_push_c", 32'(push), 32'(1));
    chk("ss_data_c", 32'(data_out), 32'hC);
    tick();
    chk("ss_push_off", 32'(push), 32'(0));

    // Backpressure after the second pop of a burst
    for (int n = 0; n < 4; n++) begin
      q[1].push_back(val(1, n));
      q[3].push_back(val(3, n));
    end
    refresh();
    tick();
    chk("bp_pop1", 32'(pop), 32'(1) << g_a);
    tick();
    chk("bp_pop2", 32'(pop), 32'(1) << g_a);
    af_next = 1'b1;
    tick();
    chk("bp_pop_afull", 32'(pop), 32'(0));
    chk("bp_push1", 32'(push), 32'(1));
    chk("bp_data1", 32'(data_out), 32'(val(g_a, 0)));
    tick();
    chk("bp_busy_exit", 32'(busy), 32'(0));
    chk("bp_push2", 32'(push), 32'(1));
    chk("bp_data2", 32'(data_out), 32'(val(g_a, 1)));
    af_next = 1'b0;
    tick();
    chk("bp_wait_busy", 32'(busy), 32'(0));
    chk("bp_wait_push", 32'(push), 32'(0));
    tick();
    chk("bp_next_grant", 32'(grant_id), 32'(g_b));
    chk("bp_next_pop", 32'(pop), 32'(1) << g_b);

    // Reset in the cycle after a pop: in-flight pops must not push
    tick();
    chk("mr_pop", 32'(pop), 32'(1) << g_b);
    rst = 1'b0;
    tick();
    chk("mr_push", 32'(push), 32'(0));
    chk("mr_busy", 32'(busy), 32'(0));
    chk("mr_pop0", 32'(pop), 32'(0));
    chk("mr_data", 32'(data_out), 32'(0));
    rst = 1'b1;
    tick();
    chk("mr_push_after", 32'(push), 32'(0));
    npush = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (push === 1'b1) npush++;
    end
    chk("drain_pushes", 32'(npush), 32'(4));
    chk("drain_busy", 32'(busy), 32'(0));

`ifdef FIFO_ARB_STRICT_PRIO_EN
    // Strict priority: source 0 wins until it runs dry
    for (int n = 0; n < 3; n++) q[0].push_back(val(0, n));
    for (int n = 0; n < 2; n++) q[3].push_back(val(3, n));
    refresh();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("sp_pop c%0d", c), 32'(pop), 32'h1);
    end
    tick();
    chk("sp_empty_exit", 32'(pop), 32'(0));
    tick();
    chk("sp_idle", 32'(busy), 32'(0));
    tick();
    chk("sp_grant3", 32'(grant_id), 32'(3));
    chk("sp_pop3", 32'(pop), 32'h8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
